shot_resolver: RTL and testbench
================================

// Module: shot_resolver
// PURPOSE
//  Resolves one player shot per fire request. It sits downstream of the debounced center button and cursor coordinate,
//  and upstream of the placement and shoot memories.
//  - Reads the placement cell and the shoot cell, classifies the shot, and writes the outcome into shoot memory.
//  - Keeps the hit and shot tallies and raises game_over once every ship cell has been hit.
//  - Borrows both memory buses through a req/gnt handshake; outside a transaction the display scan owns them.
// PARAMETERS
//  ADDR_W      7    cell address width
//  GRID_CELLS  100  valid cell addresses are 0..GRID_CELLS-1
//  SHIP_CELLS  17   number of hits that ends the game
//  RD_LAT      1    memory read latency in cycles, from oe+addr to valid rdata (range 1..3)
// PORTS
//  clk            in   1       system clock
//  reset          in   1       synchronous reset, active-high
//  fire           in   1       one-cycle shot request
//  fire_addr      in   ADDR_W  cell to shoot, sampled in the same cycle as fire
//  mem_req        out  1       request for both memory buses
//  mem_gnt        in   1       bus grant, level; held by the arbiter while mem_req is high
//  place_addr     out  ADDR_W  placement memory address
//  place_oe       out  1       placement memory read enable
//  place_rdata    in   2       placement cell: 00 empty, 01 ship, 1x reserved (treated as empty)
//  shoot_addr     out  ADDR_W  shoot memory address
//  shoot_oe       out  1       shoot memory read enable
//  shoot_we       out  1       shoot memory write enable
//  shoot_wdata    out  2       value written: 01 miss, 10 hit
//  shoot_rdata    in   2       shoot cell: 00 unshot, 01 miss, 10 hit
//  busy           out  1       high from accepted fire until the cycle after done
//  done           out  1       one-cycle result strobe
//  res_code       out  2       valid when done: 00 miss, 01 hit, 10 repeat, 11 invalid
//  hit_count      out  ADDR_W  hits so far; saturates at SHIP_CELLS
//  shot_count     out  ADDR_W  accepted new shots (miss or hit); saturates at 2**ADDR_W-1
//  game_over      out  1       sticky; set when hit_count reaches SHIP_CELLS
// BEHAVIOUR
//  Reset: all outputs are 0, the FSM returns to IDLE, both counters clear.
//   A reset mid-transaction abandons it; no write is issued on or after the reset cycle.
//  FSM states: IDLE, REQ, READ, EVAL, WRITE, DONE.
//   IDLE:  fire && !game_over moves to REQ; the address is latched into addr_q.
//          If fire_addr >= GRID_CELLS, go straight to DONE with res_code 11; no memory access.
//   REQ:   mem_req=1; wait for mem_gnt. mem_req stays 1 through WRITE.
//   READ:  entered the cycle after mem_gnt is seen. place_oe=shoot_oe=1, both addrs = addr_q, held RD_LAT cycles.
//          Both rdata values are sampled at the end of the last READ cycle.
//   EVAL:  shoot_rdata != 00 -> repeat: no write, go to DONE.
//          Otherwise a hit when place_rdata == 01, else a miss; go to WRITE.
//   WRITE: one cycle. shoot_we=1, shoot_oe=0, shoot_addr=addr_q, shoot_wdata per result.
//          shot_count+1; on a hit, hit_count+1.
//   DONE:  done=1, res_code valid, mem_req=0; return to IDLE.
//  Timing: with mem_gnt already high, done arrives RD_LAT+4 cycles after the fire cycle.
//  fire while busy, or while game_over, is ignored. A shot is never queued.
//  If mem_gnt drops before WRITE completes, stall in the current state with oe and we low.
//   Resume READ from its first cycle once mem_gnt returns.
//  game_over rises in the same cycle as the WRITE that brings hit_count to SHIP_CELLS.
//   It then stays high until reset.
//  Outputs are registered: no combinational path from any input to any output.
//  Address and enables are 0 whenever mem_req is low.
// STRUCTURE
//  Shared package or header (battleship_defs): cell encodings (EMPTY/SHIP, UNSHOT/MISS/HIT), res_code values,
//   and the GRID_CELLS / SHIP_CELLS defaults.
//  One natural sub-module: sat_counter (width, max, inc, clear), instantiated for hit_count and shot_count.
//  The FSM and datapath stay in this module.
// TESTING (memory model with RD_LAT=1; arbiter model grants the cycle after req unless stated)
//  1. Ship at cell 23; fire addr 23 -> cell 23 written 10; res_code 01; hit_count 1; shot_count 1; done 6 cycles after fire.
//  2. Empty cell 5; fire 5 -> 01 written; res 00. Fire 5 again -> no shoot_we pulse; res 10; counters unchanged.
//  3. fire_addr 100 -> done 2 cycles after fire; res 11; mem_req never rises.
//     A fire 2 cycles into a busy transaction is ignored (exactly one done).
//  4. Hit 17 ship cells -> game_over rises with the 17th write; a later fire gives no busy and no done; hit_count stays 17.
//  5. Drop mem_gnt for 3 cycles during READ -> no oe/we while low; the single correct write completes after regrant.
//     Reset asserted in WRITE-1 -> no write; all outputs 0.

Source files
------------

// File: rtl/shot_resolver_pkg.sv
// Shared battleship definitions: cell encodings, result codes, board defaults
// and the resolver state type.
package shot_resolver_pkg;

  localparam int GRID_CELLS_DEF = 100;
  localparam int SHIP_CELLS_DEF = 17;

  localparam logic [1:0] PLACE_EMPTY = 2'b00;
  localparam logic [1:0] PLACE_SHIP  = 2'b01;

  localparam logic [1:0] SHOT_UNSHOT = 2'b00;
  localparam logic [1:0] SHOT_MISS   = 2'b01;
  localparam logic [1:0] SHOT_HIT    = 2'b10;

  localparam logic [1:0] RES_MISS    = 2'b00;
  localparam logic [1:0] RES_HIT     = 2'b01;
  localparam logic [1:0] RES_REPEAT  = 2'b10;
  localparam logic [1:0] RES_INVALID = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_READ  = 3'd2,
    S_EVAL  = 3'd3,
    S_WRITE = 3'd4,
    S_DONE  = 3'd5
  } state_e;

  // Shoot-memory value recorded for a freshly resolved shot.
  function automatic logic [1:0] shot_cell(input logic is_hit);
    return is_hit ? SHOT_HIT : SHOT_MISS;
  endfunction

endpackage

// File: rtl/shot_resolver_if.sv
// Borrowed placement/shoot memory buses plus the req/gnt handshake with the
// display-scan arbiter.
interface shot_resolver_if #(
  parameter int ADDR_W = 7
) ();
  logic              mem_req;
  logic              mem_gnt;
  logic [ADDR_W-1:0] place_addr;
  logic              place_oe;
  logic [1:0]        place_rdata;
  logic [ADDR_W-1:0] shoot_addr;
  logic              shoot_oe;
  logic              shoot_we;
  logic [1:0]        shoot_wdata;
  logic [1:0]        shoot_rdata;

  modport master (
    output mem_req, place_addr, place_oe, shoot_addr, shoot_oe, shoot_we, shoot_wdata,
    input  mem_gnt, place_rdata, shoot_rdata
  );

  modport slave (
    input  mem_req, place_addr, place_oe, shoot_addr, shoot_oe, shoot_we, shoot_wdata,
    output mem_gnt, place_rdata, shoot_rdata
  );
endinterface

// File: rtl/shot_resolver_sat_counter.sv
// Saturating up-counter with a synchronous clear; holds at MAX once reached.
module sat_counter #(
  parameter int WIDTH = 7,
  parameter int MAX   = 127
) (
  input  logic             clk,
  input  logic             clear_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Next count: step by one unless already saturated.
  always_comb begin
    count_d = count_q;
    if (inc_i && (count_q != WIDTH'(MAX))) begin
      count_d = count_q + WIDTH'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Count register with synchronous clear.
  always_ff @(posedge clk) begin
    if (clear_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
endmodule

// File: rtl/shot_resolver.sv
// Resolves one shot per fire request: borrows both memories, classifies the
// target cell, records the outcome and tracks the hit/shot tallies.
module shot_resolver
  import shot_resolver_pkg::*;
#(
  parameter int ADDR_W     = 7,
  parameter int GRID_CELLS = GRID_CELLS_DEF,
  parameter int SHIP_CELLS = SHIP_CELLS_DEF,
  parameter int RD_LAT     = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fire_i,
  input  logic [ADDR_W-1:0] fire_addr_i,
  shot_resolver_if.master   mem,
  output logic              busy_o,
  output logic              done_o,
  output logic [1:0]        res_code_o,
  output logic [ADDR_W-1:0] hit_count_o,
  output logic [ADDR_W-1:0] shot_count_o,
  output logic              game_over_o
);
  state_e            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic              inv_q;
  logic [1:0]        rd_cnt_q;
  logic              mem_req_q;
  logic              rd_oe_q;
  logic              shoot_we_q;
  logic [ADDR_W-1:0] place_addr_q;
  logic [ADDR_W-1:0] shoot_addr_q;
  logic [1:0]        shoot_wdata_q;
  logic              busy_q;
  logic              done_q;
  logic [1:0]        res_q;
  logic              game_over_q;

  logic              new_shot_s;
  logic              is_hit_s;
  logic              hit_inc_s;
  logic [ADDR_W-1:0] hit_count_s;
  logic [ADDR_W-1:0] shot_count_s;

  // rdata is valid in EVAL: the address was held for RD_LAT cycles in READ.
  assign is_hit_s   = (mem.place_rdata == PLACE_SHIP);
  assign new_shot_s = (state_q == S_EVAL) && mem.mem_gnt && (mem.shoot_rdata == SHOT_UNSHOT);
  assign hit_inc_s  = new_shot_s && is_hit_s;

  sat_counter #(.WIDTH(ADDR_W), .MAX(SHIP_CELLS)) u_hit_cnt (
    .clk(clk), .clear_i(reset), .inc_i(hit_inc_s), .count_o(hit_count_s)
  );

  sat_counter #(.WIDTH(ADDR_W), .MAX((1 << ADDR_W) - 1)) u_shot_cnt (
    .clk(clk), .clear_i(reset), .inc_i(new_shot_s), .count_o(shot_count_s)
  );

  // Resolver FSM; every bus/status output is a register driven from here.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      addr_q        <= '0;
      inv_q         <= 1'b0;
      rd_cnt_q      <= 2'd0;
      mem_req_q     <= 1'b0;
      rd_oe_q       <= 1'b0;
      shoot_we_q    <= 1'b0;
      place_addr_q  <= '0;
      shoot_addr_q  <= '0;
      shoot_wdata_q <= 2'b00;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      res_q         <= 2'b00;
      game_over_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (fire_i && !game_over_q) begin
            state_q   <= S_REQ;
            addr_q    <= fire_addr_i;
            busy_q    <= 1'b1;
            inv_q     <= (fire_addr_i >= ADDR_W'(GRID_CELLS));
            mem_req_q <= (fire_addr_i < ADDR_W'(GRID_CELLS));
          end
        end
        S_REQ: begin
          if (inv_q) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            res_q   <= RES_INVALID;
          end else if (mem.mem_gnt) begin
            state_q      <= S_READ;
            rd_cnt_q     <= 2'd0;
            rd_oe_q      <= 1'b1;
            place_addr_q <= addr_q;
            shoot_addr_q <= addr_q;
          end
        end
        // A lost grant drops the read and restarts it from the first cycle.
        S_READ: begin
          if (!mem.mem_gnt || (rd_cnt_q == 2'(RD_LAT - 1))) begin
            state_q      <= mem.mem_gnt ? S_EVAL : S_REQ;
            rd_oe_q      <= 1'b0;
            place_addr_q <= '0;
            shoot_addr_q <= '0;
          end else begin
            rd_cnt_q <= rd_cnt_q + 2'd1;
          end
        end
        S_EVAL: begin
          if (!mem.mem_gnt) begin
            state_q <= S_REQ;
          end else if (mem.shoot_rdata != SHOT_UNSHOT) begin
            state_q   <= S_DONE;
            mem_req_q <= 1'b0;
            done_q    <= 1'b1;
            res_q     <= RES_REPEAT;
          end else begin
            state_q       <= S_WRITE;
            shoot_we_q    <= 1'b1;
            shoot_addr_q  <= addr_q;
            shoot_wdata_q <= shot_cell(is_hit_s);
            res_q         <= is_hit_s ? RES_HIT : RES_MISS;
            if (hit_inc_s && (hit_count_s == ADDR_W'(SHIP_CELLS - 1))) begin
              game_over_q <= 1'b1;
            end
          end
        end
        S_WRITE: begin
          state_q       <= S_DONE;
          shoot_we_q    <= 1'b0;
          shoot_addr_q  <= '0;
          shoot_wdata_q <= 2'b00;
          mem_req_q     <= 1'b0;
          done_q        <= 1'b1;
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          res_q   <= 2'b00;
          inv_q   <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign mem.mem_req     = mem_req_q;
  assign mem.place_addr  = place_addr_q;
  assign mem.place_oe    = rd_oe_q;
  assign mem.shoot_addr  = shoot_addr_q;
  assign mem.shoot_oe    = rd_oe_q;
  assign mem.shoot_we    = shoot_we_q;
  assign mem.shoot_wdata = shoot_wdata_q;
  assign busy_o          = busy_q;
  assign done_o          = done_q;
  assign res_code_o      = res_q;
  assign hit_count_o     = hit_count_s;
  assign shot_count_o    = shot_count_s;
  assign game_over_o     = game_over_q;
endmodule

// File: tb/tb_shot_resolver.sv
// Self-checking bench for shot_resolver: memory + arbiter models around the DUT
// and a board-level reference model of the game rules.
module tb_shot_resolver;
  import shot_resolver_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       fire = 1'b0;
  logic [6:0] fire_addr = 7'd0;
  logic       busy, done, go;
  logic [1:0] res;
  logic [6:0] hit_cnt, shot_cnt;

  shot_resolver_if #(.ADDR_W(7)) mem_if ();

  shot_resolver dut (
    .clk(clk), .reset(reset), .fire_i(fire), .fire_addr_i(fire_addr), .mem(mem_if),
    .busy_o(busy), .done_o(done), .res_code_o(res), .hit_count_o(hit_cnt),
    .shot_count_o(shot_cnt), .game_over_o(go)
  );

  always #5 clk = ~clk;

  // Environment: memories with one-cycle read latency, arbiter granting a cycle after req.
  logic [1:0] place_mem [128];
  logic [1:0] shoot_mem [128];
  logic       gnt_r;
  logic       drop = 1'b0;
  logic       clear_req = 1'b0;
  assign mem_if.mem_gnt = gnt_r & ~drop;

  always @(posedge clk) begin
    if (reset) begin
      gnt_r <= 1'b0;
      mem_if.place_rdata <= 2'b00;
      mem_if.shoot_rdata <= 2'b00;
    end else begin
      gnt_r <= mem_if.mem_req;
      if (mem_if.place_oe) mem_if.place_rdata <= place_mem[mem_if.place_addr];
      if (mem_if.shoot_oe) mem_if.shoot_rdata <= shoot_mem[mem_if.shoot_addr];
    end
    if (clear_req) begin
      for (int i = 0; i < 128; i++) shoot_mem[i] <= 2'b00;
    end else if (mem_if.shoot_we) begin
      shoot_mem[mem_if.shoot_addr] <= mem_if.shoot_wdata;
    end
  end

  int n_checks = 0;
  int n_fail = 0;

  // Reference model of the game rules.
  logic [1:0] m_shot [128];
  int m_hits, m_shots;
  bit m_over;

  task automatic model_fire(input int a, output bit e_done, output logic [1:0] e_res);
    e_done = !m_over;
    e_res = 2'b00;
    if (!m_over) begin
      if (a >= 100) e_res = 2'b11;
      else if (m_shot[a] != 2'b00) e_res = 2'b10;
      else begin
        if (place_mem[a] == 2'b01) begin
          m_shot[a] = 2'b10; e_res = 2'b01; m_hits++;
          if (m_hits == 17) m_over = 1'b1;
        end else begin
          m_shot[a] = 2'b01; e_res = 2'b00;
        end
        if (m_shots < 127) m_shots++;
      end
    end
  endtask

  task automatic new_game();
    @(negedge clk);
    reset = 1'b1; clear_req = 1'b1;
    m_hits = 0; m_shots = 0; m_over = 1'b0;
    for (int i = 0; i < 128; i++) m_shot[i] = 2'b00;
    repeat (2) @(posedge clk);
    #1; reset = 1'b0; clear_req = 1'b0;
  endtask

  task automatic empty_board();
    for (int i = 0; i < 128; i++) place_mem[i] = 2'b00;
  endtask

  // Observations from one fire window.
  int o_done_cnt, o_lat, o_we_cnt, o_idle_bad, o_gnt_bad;
  bit o_req_seen, o_busy_seen, o_go_we, o_post_rst_nz;
  logic [1:0] o_res;

  task automatic do_shot(input int a, input int refire_at, input int drop_at, input int reset_at, input int n_cyc);
    bit gl_prev;
    o_done_cnt = 0; o_lat = -1; o_we_cnt = 0; o_idle_bad = 0; o_gnt_bad = 0;
    o_req_seen = 0; o_busy_seen = 0; o_go_we = 0; o_post_rst_nz = 0; o_res = 2'b00;
    gl_prev = 0;
    @(negedge clk);
    fire = 1'b1; fire_addr = 7'(a);
    for (int cyc = 1; cyc <= n_cyc; cyc++) begin
      @(posedge clk); #1;
      fire = (cyc == refire_at);
      if (cyc == refire_at) fire_addr = 7'(a + 1);
      if (cyc == drop_at) drop = 1'b1;
      if (cyc == drop_at + 3) drop = 1'b0;
      reset = (cyc == reset_at);
      if (cyc == reset_at + 1)
        o_post_rst_nz = |{busy, done, res, hit_cnt, shot_cnt, go, mem_if.mem_req, mem_if.place_oe,
                          mem_if.shoot_oe, mem_if.shoot_we, mem_if.place_addr, mem_if.shoot_addr, mem_if.shoot_wdata};
      if (mem_if.mem_req) o_req_seen = 1;
      if (busy) o_busy_seen = 1;
      if (!mem_if.mem_req && (|{mem_if.place_oe, mem_if.shoot_oe, mem_if.shoot_we, mem_if.place_addr, mem_if.shoot_addr}))
        o_idle_bad++;
      if (!mem_if.mem_gnt && gl_prev && (mem_if.place_oe || mem_if.shoot_oe || mem_if.shoot_we)) o_gnt_bad++;
      gl_prev = !mem_if.mem_gnt;
      if (mem_if.shoot_we) begin o_we_cnt++; o_go_we = go; end
      if (done) begin
        o_done_cnt++;
        if (o_done_cnt == 1) begin o_lat = cyc; o_res = res; end
      end
    end
    fire = 1'b0; drop = 1'b0; reset = 1'b0;
  endtask

  task automatic test_reset();
    new_game();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    n_checks++; if (res !== 2'b00) begin n_fail++; $display("FAIL reset_res: got %b want 00", res); end
    n_checks++; if ({hit_cnt, shot_cnt, go} !== 15'd0) begin n_fail++; $display("FAIL reset_counts: got hit %0d shot %0d go %b want 0", hit_cnt, shot_cnt, go); end
    n_checks++; if ({mem_if.mem_req, mem_if.place_oe, mem_if.shoot_oe, mem_if.shoot_we} !== 4'd0) begin n_fail++; $display("FAIL reset_bus: got %b want 0000", {mem_if.mem_req, mem_if.place_oe, mem_if.shoot_oe, mem_if.shoot_we}); end
  endtask

  task automatic test_hit();
    bit e_d; logic [1:0] e_r;
    empty_board(); place_mem[23] = 2'b01;
    new_game();
    model_fire(23, e_d, e_r);
    do_shot(23, -1, -1, -1, 14);
    n_checks++; if (o_lat !== 6) begin n_fail++; $display("FAIL hit_latency: got %0d want 6", o_lat); end
    n_checks++; if (o_res !== 2'b01 || e_r !== 2'b01) begin n_fail++; $display("FAIL hit_res: got %b want 01", o_res); end
    n_checks++; if (shoot_mem[23] !== 2'b10) begin n_fail++; $display("FAIL hit_cell: got %b want 10", shoot_mem[23]); end
    n_checks++; if (hit_cnt !== 7'(m_hits) || shot_cnt !== 7'(m_shots)) begin n_fail++; $display("FAIL hit_counts: got %0d/%0d want %0d/%0d", hit_cnt, shot_cnt, m_hits, m_shots); end
    n_checks++; if (o_we_cnt !== 1 || o_done_cnt !== 1) begin n_fail++; $display("FAIL hit_pulses: got we %0d done %0d want 1/1", o_we_cnt, o_done_cnt); end
    n_checks++; if (o_idle_bad !== 0) begin n_fail++; $display("FAIL hit_idle_bus: got %0d want 0", o_idle_bad); end
  endtask

  task automatic test_miss_repeat();
    bit e_d; logic [1:0] e_r;
    model_fire(5, e_d, e_r);
    do_shot(5, -1, -1, -1, 14);
    n_checks++; if (o_res !== 2'b00 || shoot_mem[5] !== 2'b01) begin n_fail++; $display("FAIL miss: got res %b cell %b want 00/01", o_res, shoot_mem[5]); end
    model_fire(5, e_d, e_r);
    do_shot(5, -1, -1, -1, 14);
    n_checks++; if (o_res !== 2'b10 || o_we_cnt !== 0) begin n_fail++; $display("FAIL repeat: got res %b we %0d want 10/0", o_res, o_we_cnt); end
    n_checks++; if (hit_cnt !== 7'(m_hits) || shot_cnt !== 7'(m_shots)) begin n_fail++; $display("FAIL repeat_counts: got %0d/%0d want %0d/%0d", hit_cnt, shot_cnt, m_hits, m_shots); end
  endtask

  task automatic test_invalid_and_busy();
    bit e_d; logic [1:0] e_r;
    model_fire(100, e_d, e_r);
    do_shot(100, -1, -1, -1, 8);
    n_checks++; if (o_lat !== 2 || o_res !== 2'b11) begin n_fail++; $display("FAIL invalid: got lat %0d res %b want 2/11", o_lat, o_res); end
    n_checks++; if (o_req_seen !== 1'b0) begin n_fail++; $display("FAIL invalid_req: got %b want 0", o_req_seen); end
    model_fire(40, e_d, e_r);
    do_shot(40, 2, -1, -1, 14);
    n_checks++; if (o_done_cnt !== 1 || o_res !== e_r) begin n_fail++; $display("FAIL busy_ignore: got done %0d res %b want 1/%b", o_done_cnt, o_res, e_r); end
    n_checks++; if (shoot_mem[41] !== 2'b00 || shoot_mem[40] !== m_shot[40]) begin n_fail++; $display("FAIL busy_cells: got %b/%b want 00/%b", shoot_mem[41], shoot_mem[40], m_shot[40]); end
  endtask

  task automatic test_game_over();
    bit e_d; logic [1:0] e_r;
    empty_board();
    for (int i = 0; i < 17; i++) place_mem[i * 5] = 2'b01;
    new_game();
    model_fire(1, e_d, e_r);
    do_shot(1, -1, -1, -1, 12);
    for (int i = 0; i < 17; i++) begin
      model_fire(i * 5, e_d, e_r);
      do_shot(i * 5, -1, -1, -1, 12);
      n_checks++; if (o_we_cnt !== 1 || o_go_we !== m_over) begin n_fail++; $display("FAIL go_with_write%0d: got we %0d go %b want 1/%b", i, o_we_cnt, o_go_we, m_over); end
    end
    n_checks++; if (go !== 1'b1 || hit_cnt !== 7'd17) begin n_fail++; $display("FAIL go_set: got go %b hits %0d want 1/17", go, hit_cnt); end
    model_fire(99, e_d, e_r);
    do_shot(99, -1, -1, -1, 10);
    n_checks++; if (o_busy_seen !== 1'b0 || o_done_cnt !== 0) begin n_fail++; $display("FAIL go_ignore: got busy %b done %0d want 0/0", o_busy_seen, o_done_cnt); end
    n_checks++; if (hit_cnt !== 7'd17 || go !== 1'b1) begin n_fail++; $display("FAIL go_hold: got hits %0d go %b want 17/1", hit_cnt, go); end
  endtask

  task automatic test_gnt_drop_and_reset();
    bit e_d; logic [1:0] e_r;
    empty_board(); place_mem[23] = 2'b01;
    new_game();
    model_fire(23, e_d, e_r);
    do_shot(23, -1, 3, -1, 14);
    n_checks++; if (o_gnt_bad !== 0) begin n_fail++; $display("FAIL drop_bus_quiet: got %0d want 0", o_gnt_bad); end
    n_checks++; if (o_we_cnt !== 1 || shoot_mem[23] !== 2'b10) begin n_fail++; $display("FAIL drop_write: got we %0d cell %b want 1/10", o_we_cnt, shoot_mem[23]); end
    n_checks++; if (o_lat !== 10 || o_res !== e_r) begin n_fail++; $display("FAIL drop_done: got lat %0d res %b want 10/%b", o_lat, o_res, e_r); end
    new_game();
    do_shot(23, -1, -1, 4, 14);
    n_checks++; if (o_we_cnt !== 0 || shoot_mem[23] !== 2'b00) begin n_fail++; $display("FAIL rst_no_write: got we %0d cell %b want 0/00", o_we_cnt, shoot_mem[23]); end
    n_checks++; if (o_post_rst_nz !== 1'b0 || o_done_cnt !== 0) begin n_fail++; $display("FAIL rst_outputs: got nz %b done %0d want 0/0", o_post_rst_nz, o_done_cnt); end
  endtask

  task automatic test_random();
    bit e_d; logic [1:0] e_r;
    int a, v, bad;
    for (int i = 0; i < 128; i++) begin
      v = $urandom_range(0, 9);
      place_mem[i] = (v < 3) ? 2'b01 : (v == 3) ? 2'b10 : (v == 4) ? 2'b11 : 2'b00;
    end
    new_game();
    for (int k = 0; k < 120; k++) begin
      a = $urandom_range(0, 127);
      model_fire(a, e_d, e_r);
      do_shot(a, -1, ($urandom_range(0, 3) == 0) ? 3 : -1, -1, 14);
      n_checks++;
      if (o_done_cnt !== int'(e_d) || (e_d && o_res !== e_r) || hit_cnt !== 7'(m_hits) ||
          shot_cnt !== 7'(m_shots) || go !== m_over || o_idle_bad !== 0 || o_gnt_bad !== 0) begin
        n_fail++;
        $display("FAIL rand%0d addr %0d: got done %0d res %b hit %0d shot %0d go %b bus %0d/%0d want %0d %b %0d %0d %b 0/0",
                 k, a, o_done_cnt, o_res, hit_cnt, shot_cnt, go, o_idle_bad, o_gnt_bad, e_d, e_r, m_hits, m_shots, m_over);
      end
    end
    bad = 0;
    for (int i = 0; i < 100; i++) if (shoot_mem[i] !== m_shot[i]) bad++;
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL rand_board: got %0d differing cells want 0", bad); end
  endtask

  initial begin
    test_reset();
    test_hit();
    test_miss_repeat();
    test_invalid_and_busy();
    test_game_over();
    test_gnt_drop_and_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
